// File: rtl/fifo_rd_stream.sv
// Drains a synchronous read-latency-1 FIFO into a valid/ready stream with m_last packet framing.
// Optional macro FIFO_RD_STREAM_WORD_CNT_EN enables the 16-bit accepted-word counter on word_cnt.
module fifo_rd_stream #(
  parameter int WIDTH   = 8,
  parameter int PKT_LEN = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic [15:0]      word_cnt
);

  localparam logic [15:0] LAST_IDX = 16'(PKT_LEN - 1);

  logic [WIDTH-1:0] buf_q [2];
  logic [WIDTH-1:0] buf_d [2];
  logic [1:0]       occ_q, occ_d;
  logic             inflight_q;
  logic [15:0]      pkt_idx_q, pkt_idx_d;
  logic             pop;
  logic [1:0]       committed;

  assign m_valid = ~rst & (occ_q != 2'd0);
  assign pop     = m_valid & m_ready;
  assign m_data  = buf_q[0];
  assign m_last  = m_valid & (pkt_idx_q == LAST_IDX);

  // Slots already owned by buffered or in-flight words once this cycle's pop leaves.
  assign committed  = occ_q + {1'b0, inflight_q} - {1'b0, pop};
  assign fifo_rd_en = ~rst & ~fifo_empty & (committed < 2'd2);

  // NOTE: combinational next-state uses blocking '=' with every output defaulted first,
  // so the later in-flight write sees the post-pop occupancy and no latch is inferred.
  always_comb begin
    buf_d     = buf_q;
    occ_d     = occ_q;
    pkt_idx_d = pkt_idx_q;
    if (pop) begin
      buf_d[0]  = buf_q[1];
      occ_d     = occ_q - 2'd1;
      pkt_idx_d = (pkt_idx_q == LAST_IDX) ? 16'd0 : pkt_idx_q + 16'd1;
    end
    if (inflight_q) begin
      buf_d[occ_d[0]] = fifo_dout;
      occ_d           = occ_d + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      pkt_idx_q  <= 16'd0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= fifo_rd_en;
      pkt_idx_q  <= pkt_idx_d;
    end
  end

  // NOTE: data storage is deliberately not reset; occ_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

`ifdef FIFO_RD_STREAM_WORD_CNT_EN
  logic [15:0] word_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)      word_cnt_q <= 16'd0;
    else if (pop) word_cnt_q <= word_cnt_q + 16'd1;
  end

  assign word_cnt = rst ? 16'd0 : word_cnt_q;
`else
  assign word_cnt = 16'd0;
`endif

endmodule
